// File: rtl/sap_pkg.sv
// Shared definitions for the SAP program-RAM loading path.
//
// Contents:
//   RAM_ADDR_W / RAM_DATA_W : geometry of the 256 x 16-bit program RAM
//   loader_state_t          : loader FSM states, shared so the control unit
//                             and the bench can decode the loader state
package sap_pkg;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RX_HI  = 3'd1,
        RX_LO  = 3'd2,
        SETUP  = 3'd3,
        STROBE = 3'd4,
        HOLD   = 3'd5,
        DONE   = 3'd6
    } loader_state_t;

endpackage

// File: rtl/ram_program_loader.sv
// Program RAM loader.
//
// Pairs bytes from a valid/ready byte stream (high byte first) into 16-bit
// words and writes WORD_COUNT of them into the program RAM through its
// programming port, starting at START_ADDRESS. The RAM write-enable is
// edge-triggered, so every word goes through SETUP (address/data stable,
// we low), STROBE (we high for one cycle) and HOLD (we low, address/data
// unchanged).
//
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_start               : begin a load (sampled only in IDLE or DONE)
//   i_byte_valid, i_byte  : byte stream input
//   o_byte_ready          : loader takes a byte this cycle
//   o_program_mode        : RAM program mode, high for the whole load
//   o_program_address     : RAM programming address
//   o_program_data        : RAM programming data
//   o_write_enable        : RAM write strobe (RAM captures on rising edge)
//   o_busy                : load in progress
//   o_done                : load finished, held until next start or reset
//   o_word_count          : words written since the last start
module ram_program_loader
    import sap_pkg::*;
#(
    parameter int                    WORD_COUNT    = 16,
    parameter logic [RAM_ADDR_W-1:0] START_ADDRESS = 8'h00
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_byte_ready,
    output logic                  o_program_mode,
    output logic [RAM_ADDR_W-1:0] o_program_address,
    output logic [RAM_DATA_W-1:0] o_program_data,
    output logic                  o_write_enable,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [8:0]            o_word_count
);

    // Count is 9 bits so a full 256-word load is representable.
    localparam logic [8:0] LAST_COUNT = 9'(WORD_COUNT);

    loader_state_t           state_reg, state_next;
    logic [RAM_ADDR_W-1:0]   addr_reg, addr_next;
    logic [RAM_DATA_W-1:0]   data_reg, data_next;
    logic [8:0]              count_reg, count_next;

    // Output flags are registered copies of a decode of the next state, so
    // every output comes straight from a flop and none depends on
    // i_byte_valid combinationally.
    logic ready_reg, ready_next;
    logic mode_reg, mode_next;
    logic we_reg, we_next;
    logic busy_reg, busy_next;
    logic done_reg, done_next;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        count_next = count_reg;

        unique case (state_reg)
            IDLE, DONE: begin
                if (i_start) begin
                    addr_next  = START_ADDRESS;
                    count_next = 9'd0;
                    state_next = RX_HI;
                end
            end
            RX_HI: begin
                if (i_byte_valid && ready_reg) begin
                    data_next[15:8] = i_byte;
                    state_next      = RX_LO;
                end
            end
            RX_LO: begin
                if (i_byte_valid && ready_reg) begin
                    data_next[7:0] = i_byte;
                    state_next     = SETUP;
                end
            end
            SETUP: begin
                state_next = STROBE;
            end
            STROBE: begin
                state_next = HOLD;
            end
            HOLD: begin
                // Address wraps naturally at 8 bits.
                count_next = count_reg + 9'd1;
                addr_next  = addr_reg + 8'd1;
                state_next = (count_reg + 9'd1 == LAST_COUNT) ? DONE : RX_HI;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        ready_next = (state_next == RX_HI) || (state_next == RX_LO);
        busy_next  = (state_next != IDLE) && (state_next != DONE);
        mode_next  = busy_next;
        we_next    = (state_next == STROBE);
        done_next  = (state_next == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // A partially received word is discarded and a strobe in flight
            // is dropped without producing another edge.
            state_reg <= IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            count_reg <= '0;
            ready_reg <= 1'b0;
            mode_reg  <= 1'b0;
            we_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            count_reg <= count_next;
            ready_reg <= ready_next;
            mode_reg  <= mode_next;
            we_reg    <= we_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign o_byte_ready      = ready_reg;
    assign o_program_mode    = mode_reg;
    assign o_program_address = addr_reg;
    assign o_program_data    = data_reg;
    assign o_write_enable    = we_reg;
    assign o_busy            = busy_reg;
    assign o_done            = done_reg;
    assign o_word_count      = count_reg;

endmodule

// File: tb/tb_ram_program_loader.sv
// Self-checking bench for ram_program_loader.
//
// Three loader instances with different parameters:
//   inst0: WORD_COUNT=2, START_ADDRESS=00
//   inst1: WORD_COUNT=4, START_ADDRESS=00
//   inst2: WORD_COUNT=4, START_ADDRESS=FE
// Each instance has a byte source fed from a queue, a queue of expected
// (address, data) writes derived from the bytes handed to the source, and a
// RAM model that captures on rising edges of the write enable.
module tb_ram_program_loader;

    logic clk;
    logic rst;

    logic        start_s  [3];
    logic        ready_o  [3];
    logic        mode_o   [3];
    logic        we_o     [3];
    logic        busy_o   [3];
    logic        done_o   [3];
    logic [7:0]  addr_o   [3];
    logic [15:0] data_o   [3];
    logic [8:0]  cnt_o    [3];

    logic [7:0]  src_q    [3][$];
    int          gap_cfg  [3];
    logic        idle_valid [3];
    logic [23:0] exp_q    [3][$];
    logic [15:0] ram_m    [3][256];

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h", name, inst, act, exp);
        end
    endtask

    function automatic int wc_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic logic [7:0] sa_of(input int i);
        return (i == 2) ? 8'hFE : 8'h00;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int         WC = (gi == 0) ? 2 : 4;
        localparam logic [7:0] SA = (gi == 2) ? 8'hFE : 8'h00;

        logic       valid;
        logic [7:0] byte_v;

        ram_program_loader #(
            .WORD_COUNT   (WC),
            .START_ADDRESS(SA)
        ) dut (
            .i_clk            (clk),
            .i_reset          (rst),
            .i_start          (start_s[gi]),
            .i_byte_valid     (valid),
            .i_byte           (byte_v),
            .o_byte_ready     (ready_o[gi]),
            .o_program_mode   (mode_o[gi]),
            .o_program_address(addr_o[gi]),
            .o_program_data   (data_o[gi]),
            .o_write_enable   (we_o[gi]),
            .o_busy           (busy_o[gi]),
            .o_done           (done_o[gi]),
            .o_word_count     (cnt_o[gi])
        );

        // Byte source: decides at each falling edge what is offered at the
        // next rising edge; ready is registered so it is already settled.
        initial begin : source
            int gap_left;
            gap_left = 0;
            valid    = 1'b0;
            byte_v   = 8'h00;
            forever begin
                @(negedge clk);
                if (gap_left > 0) begin
                    valid = 1'b0;
                    gap_left--;
                end else if (src_q[gi].size() > 0) begin
                    valid  = 1'b1;
                    byte_v = src_q[gi][0];
                    if (ready_o[gi] && !rst) begin
                        void'(src_q[gi].pop_front());
                        gap_left = gap_cfg[gi];
                    end
                end else begin
                    valid  = idle_valid[gi];
                    byte_v = 8'hAA;
                end
            end
        end

        // Per-cycle compare against the expected-write queue and the
        // output rules; RAM model captures on the write-enable rising edge.
        initial begin : monitor
            logic        prev_we;
            logic [7:0]  prev_addr, pulse_addr;
            logic [15:0] prev_data, pulse_data;
            int          we_len;
            logic [23:0] e;
            prev_we    = 1'b0;
            prev_addr  = 8'h00;
            prev_data  = 16'h0000;
            pulse_addr = 8'h00;
            pulse_data = 16'h0000;
            we_len     = 0;
            forever begin
                @(negedge clk);
                chk("mode_matches_busy", gi, 32'(mode_o[gi]), 32'(busy_o[gi]));
                chk("ready_outside_load", gi, 32'(ready_o[gi] & ~busy_o[gi]), 0);
                chk("we_outside_load", gi, 32'(we_o[gi] & ~busy_o[gi]), 0);
                chk("done_while_busy", gi, 32'(done_o[gi] & busy_o[gi]), 0);
                if (done_o[gi])
                    chk("count_in_done", gi, 32'(cnt_o[gi]), WC);

                if (we_o[gi] && !prev_we) begin
                    chk("setup_addr", gi, 32'(addr_o[gi]), 32'(prev_addr));
                    chk("setup_data", gi, 32'(data_o[gi]), 32'(prev_data));
                    if (exp_q[gi].size() == 0) begin
                        chk("unexpected_write", gi, 32'(addr_o[gi]), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q[gi].pop_front();
                        chk("write_addr", gi, 32'(addr_o[gi]), 32'(e[23:16]));
                        chk("write_data", gi, 32'(data_o[gi]), 32'(e[15:0]));
                    end
                    $display("inst%0d write addr=%02h data=%04h", gi, addr_o[gi], data_o[gi]);
                    ram_m[gi][addr_o[gi]] = data_o[gi];
                    pulse_addr = addr_o[gi];
                    pulse_data = data_o[gi];
                    we_len     = 1;
                end else if (we_o[gi] && prev_we) begin
                    we_len++;
                end else if (!we_o[gi] && prev_we && !rst) begin
                    chk("strobe_length", gi, we_len, 1);
                    chk("hold_addr", gi, 32'(addr_o[gi]), 32'(pulse_addr));
                    chk("hold_data", gi, 32'(data_o[gi]), 32'(pulse_data));
                end
                prev_we   = we_o[gi];
                prev_addr = addr_o[gi];
                prev_data = data_o[gi];
            end
        end
    end

    // Hand the bytes to the source and derive the writes they must produce.
    task automatic queue_load(input int i, input logic [7:0] b[]);
        logic [7:0] a;
        a = sa_of(i);
        for (int k = 0; k < b.size() / 2; k++) begin
            src_q[i].push_back(b[2*k]);
            src_q[i].push_back(b[2*k+1]);
            exp_q[i].push_back({a, b[2*k], b[2*k+1]});
            a = a + 8'd1;
        end
    endtask

    task automatic do_start(input int i);
        @(negedge clk);
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, output int we_cycles);
        int c;
        we_cycles = 0;
        c = 0;
        while (!done_o[i] && c < budget) begin
            @(negedge clk);
            if (we_o[i]) we_cycles++;
            c++;
        end
        chk("done_within_budget", i, 32'(done_o[i]), 1);
    endtask

    task automatic check_reset_vals(input int i);
        chk("rst_ready", i, 32'(ready_o[i]), 0);
        chk("rst_mode",  i, 32'(mode_o[i]),  0);
        chk("rst_addr",  i, 32'(addr_o[i]),  0);
        chk("rst_data",  i, 32'(data_o[i]),  0);
        chk("rst_we",    i, 32'(we_o[i]),    0);
        chk("rst_busy",  i, 32'(busy_o[i]),  0);
        chk("rst_done",  i, 32'(done_o[i]),  0);
        chk("rst_count", i, 32'(cnt_o[i]),   0);
    endtask

    task automatic random_bytes(input int n, output logic [7:0] b[]);
        b = new[n];
        for (int k = 0; k < n; k++) b[k] = 8'($urandom_range(0, 255));
    endtask

    initial begin : main
        logic [7:0] b[];
        int         wec;
        int         n;
        logic       last_we;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_s[i]    = 1'b0;
            gap_cfg[i]    = 0;
            idle_valid[i] = 1'b0;
            for (int a = 0; a < 256; a++) ram_m[i][a] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset_vals(i);
        rst = 1'b0;
        $display("reset values checked");

        // Two words, valid held high: DONE exactly 11 cycles after start.
        b = new[4];
        b[0] = 8'h12; b[1] = 8'h34; b[2] = 8'h56; b[3] = 8'h78;
        queue_load(0, b);
        @(negedge clk);
        start_s[0] = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_s[0] = 1'b0;
                chk("rx_hi_ready", 0, 32'(ready_o[0]), 1);
                chk("rx_hi_mode", 0, 32'(mode_o[0]), 1);
                chk("start_addr", 0, 32'(addr_o[0]), 0);
            end
            if (c == 10) chk("done_cycle10", 0, 32'(done_o[0]), 0);
            if (c == 11) chk("done_cycle11", 0, 32'(done_o[0]), 1);
        end
        chk("ram0_word0", 0, 32'(ram_m[0][0]), 32'h1234);
        chk("ram0_word1", 0, 32'(ram_m[0][1]), 32'h5678);
        chk("count_two", 0, 32'(cnt_o[0]), 2);
        chk("all_writes_seen", 0, exp_q[0].size(), 0);
        chk("mode_off_in_done", 0, 32'(mode_o[0]), 0);
        $display("load valid-high done");

        // Valid high while in DONE: nothing accepted, nothing written.
        idle_valid[0] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("done_ready_low", 0, 32'(ready_o[0]), 0);
            chk("done_we_low", 0, 32'(we_o[0]), 0);
            chk("done_held", 0, 32'(done_o[0]), 1);
        end
        idle_valid[0] = 1'b0;

        // Same bytes with 3-cycle gaps between every byte.
        ram_m[0][0] = 16'h0000;
        ram_m[0][1] = 16'h0000;
        gap_cfg[0] = 3;
        queue_load(0, b);
        do_start(0);
        wait_done(0, 300, wec);
        chk("gap_we_cycles", 0, wec, 2);
        chk("gap_ram_word0", 0, 32'(ram_m[0][0]), 32'h1234);
        chk("gap_ram_word1", 0, 32'(ram_m[0][1]), 32'h5678);
        chk("gap_all_writes", 0, exp_q[0].size(), 0);
        gap_cfg[0] = 0;
        $display("load with gaps done");

        // Start pulsed during RX_LO of word 0 is ignored.
        random_bytes(4, b);
        queue_load(0, b);
        do_start(0);
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        chk("start_ignored_busy", 0, 32'(busy_o[0]), 1);
        chk("start_ignored_addr", 0, 32'(addr_o[0]), 0);
        chk("start_ignored_count", 0, 32'(cnt_o[0]), 0);
        wait_done(0, 300, wec);
        chk("restart_we_cycles", 0, wec, 2);
        chk("restart_ram_word0", 0, 32'(ram_m[0][0]), 32'({b[0], b[1]}));
        chk("restart_all_writes", 0, exp_q[0].size(), 0);
        $display("ignored start done");

        // Valid high while in IDLE: nothing accepted, nothing written.
        idle_valid[1] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("idle_ready_low", 1, 32'(ready_o[1]), 0);
            chk("idle_we_low", 1, 32'(we_o[1]), 0);
        end
        idle_valid[1] = 1'b0;

        // Reset while word 1 is in STROBE.
        random_bytes(8, b);
        queue_load(1, b);
        do_start(1);
        n = 0;
        last_we = 1'b0;
        for (int c = 0; c < 100 && n < 2; c++) begin
            @(negedge clk);
            if (we_o[1] && !last_we) n++;
            last_we = we_o[1];
        end
        chk("reached_word1_strobe", 1, n, 2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals(1);
        src_q[1].delete();
        exp_q[1].delete();
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ram_word0", 1, 32'(ram_m[1][0]), 32'({b[0], b[1]}));
        random_bytes(8, b);
        queue_load(1, b);
        do_start(1);
        chk("reload_addr", 1, 32'(addr_o[1]), 0);
        wait_done(1, 300, wec);
        for (int k = 0; k < 4; k++)
            chk("reload_ram", 1, 32'(ram_m[1][k]), 32'({b[2*k], b[2*k+1]}));
        chk("reload_count", 1, 32'(cnt_o[1]), 4);
        $display("reset mid-load done");

        // Address wrap from FE.
        b = new[8];
        for (int k = 0; k < 8; k++) b[k] = 8'(k);
        queue_load(2, b);
        do_start(2);
        chk("wrap_first_addr", 2, 32'(addr_o[2]), 32'hFE);
        wait_done(2, 300, wec);
        chk("wrap_count", 2, 32'(cnt_o[2]), 4);
        chk("wrap_ram_fe", 2, 32'(ram_m[2][8'hFE]), 32'h0001);
        chk("wrap_ram_ff", 2, 32'(ram_m[2][8'hFF]), 32'h0203);
        chk("wrap_ram_00", 2, 32'(ram_m[2][8'h00]), 32'h0405);
        chk("wrap_ram_01", 2, 32'(ram_m[2][8'h01]), 32'h0607);
        $display("address wrap done");

        // Randomized loads with random gaps on every instance.
        for (int r = 0; r < 9; r++) begin
            int i;
            i = r % 3;
            gap_cfg[i] = $urandom_range(0, 2);
            random_bytes(2 * wc_of(i), b);
            queue_load(i, b);
            do_start(i);
            wait_done(i, 400, wec);
            chk("rand_we_cycles", i, wec, wc_of(i));
            chk("rand_all_writes", i, exp_q[i].size(), 0);
            chk("rand_count", i, 32'(cnt_o[i]), 32'(wc_of(i)));
            gap_cfg[i] = 0;
            $display("random load %0d on inst%0d done", r, i);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_program_loader.md
# ram_program_loader

Sequential front-end that fills the 256 x 16-bit program RAM from a byte stream (UART receiver or test host) before the CPU runs. It accepts bytes through a valid/ready handshake, pairs them high byte first into 16-bit words, and drives the RAM's program-mode address, data and write-enable pins. The write-enable is edge-triggered, so the block owns a setup/strobe/hold sequence for each word. It sits directly upstream of the RAM's programming port and holds program mode asserted for the whole load.

## Interface
Parameters:
- `WORD_COUNT`, default 16: number of words loaded per start, legal range 1..256.
- `START_ADDRESS`, default 8'h00: first RAM address written.

Ports:
- `i_clk` in 1: the single clock. All logic is on the rising edge.
- `i_reset` in 1: synchronous reset, active-high.
- `i_start` in 1: begins a load. It is sampled only in IDLE or DONE.
- `i_byte_valid` in 1: source has a byte on `i_byte`.
- `i_byte` in 8: stream byte.
- `o_byte_ready` out 1: the loader accepts a byte this cycle.
- `o_program_mode` out 1: connects to the RAM `i_program_mode`.
- `o_program_address` out 8: connects to the RAM `i_program_address`.
- `o_program_data` out 16: connects to the RAM `i_program_data`.
- `o_write_enable` out 1: connects to the RAM `i_write_enable`. The RAM captures on its rising edge.
- `o_busy` out 1: high in every state except IDLE and DONE.
- `o_done` out 1: high in DONE.
- `o_word_count` out 9: number of words written since the last start.

## Operation
- FSM states are IDLE, RX_HI, RX_LO, SETUP, STROBE, HOLD and DONE.
- IDLE or DONE with `i_start` high:
  - address becomes `START_ADDRESS`;
  - count becomes 0;
  - `o_done` clears;
  - the FSM moves to RX_HI.
- RX_HI: `o_byte_ready`=1. On valid&ready, data[15:8] takes `i_byte` and the FSM moves to RX_LO.
- RX_LO: `o_byte_ready`=1. On valid&ready, data[7:0] takes `i_byte` and the FSM moves to SETUP.
- SETUP: address and data are stable, `o_write_enable`=0. This gives at least 1 cycle of setup before the rising edge.
- STROBE: `o_write_enable`=1 for exactly one cycle.
- HOLD: `o_write_enable`=0, with address and data unchanged. On exit:
  - count increments;
  - address increments modulo 256;
  - the FSM moves to DONE if the new count equals `WORD_COUNT`, otherwise to RX_HI.
- DONE: `o_program_mode`=0 and `o_done`=1. This is held until `i_start` or reset.
- `o_program_mode`=1 in every state from RX_HI through HOLD.
- `o_byte_ready` is 0 outside RX_HI and RX_LO. While ready is low, bytes are neither consumed nor dropped.
- The block holds no RAM contents and does not read back.

## Timing
- Reset values:
  - state = IDLE;
  - `o_byte_ready` = 0;
  - `o_program_mode` = 0;
  - `o_program_address` = 8'h00;
  - `o_program_data` = 16'h0000;
  - `o_write_enable` = 0;
  - `o_busy` = 0;
  - `o_done` = 0;
  - `o_word_count` = 0.
- Reset mid-load:
  - all outputs return to their reset values on the next edge;
  - if reset lands in STROBE, `o_write_enable` falls and no further edge is produced;
  - a partially received word is discarded.
- All outputs are registered. `o_byte_ready` is decoded from registered state only and never depends on `i_byte_valid`.
- Latency: 1 cycle for `i_start` to reach RX_HI. When `i_byte_valid` is held high, each word takes 5 cycles (RX_HI, RX_LO, SETUP, STROBE, HOLD).
- Minimum load time: 1 + 5 × `WORD_COUNT` cycles. DONE follows the last HOLD by 1 cycle.
- `i_start` is ignored while `o_busy`=1. It restarts from DONE.
- If `i_byte_valid` drops in RX_HI or RX_LO, the FSM waits indefinitely. There is no timeout.
- Address wrap: with `START_ADDRESS`=8'hF0 and `WORD_COUNT`=32, writes go to F0..FF and then 00..0F. Wrap is legal.
- `o_word_count` is 9 bits wide so that 256 is representable. It equals `WORD_COUNT` in DONE.

## Structure
- Shared package `sap_pkg` holds:
  - `RAM_ADDR_W`=8 and `RAM_DATA_W`=16;
  - the `loader_state_t` enum (IDLE..DONE), so that the control unit and bench can decode state.
- The block is a single module with no sub-module. The strobe sequencing is three FSM states and does not justify a separate module.

## Test plan
- `WORD_COUNT`=2, bytes 12,34,56,78 with valid held high. Required: rising edges on `o_write_enable` with (addr 00, data 1234) and then (addr 01, data 5678). `o_done` is high at cycle 11 after start, and RAM words 0 and 1 read back as 1234 and 5678.
- Same stimulus with valid deasserted for 3 cycles between every byte. Required: identical RAM contents, no byte accepted while valid is low, and `o_write_enable` never asserted during waits.
- `i_start` pulsed during RX_LO of word 0. Required: it is ignored, address stays 00, and the load completes normally.
- Reset asserted in STROBE of word 1 (`WORD_COUNT`=4). Required: next cycle all outputs are at reset values, word 0 is in RAM, and a subsequent start reloads from address 00.
- `START_ADDRESS`=FE and `WORD_COUNT`=4 with bytes 00..07. Required: writes go to FE, FF, 00 and 01 with data 0001, 0203, 0405 and 0607, and `o_word_count`=4.
- `i_byte_valid` high while in IDLE and DONE. Required: `o_byte_ready` stays 0 and no write occurs.
